// File: rtl/vram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vram_write_scheduler
// Description : Orders every background-VRAM write so that it lands only
//               while the timing generator reports `writable`. CPU byte
//               writes are buffered in a FIFO and drained one per clock; a
//               fill engine writes a run of identical bytes over an address
//               range. A fill requested while queued CPU writes are still
//               draining is held pending until the FIFO empties, which keeps
//               program order.
// Ports       : clk, rst (async, active low)
//               writable                      - VRAM write window
//               req_valid/req_ready/req_addr/req_data - CPU write handshake
//               fill_start/fill_addr/fill_len/fill_data, fill_busy - fill
//               vram_we/vram_addr/vram_data   - VRAM write port
//               fifo_level, idle              - status
//               addr_err (only with VRAM_WRITE_SCHED_ADDR_CHECK_EN)
// Options     : VRAM_WRITE_SCHED_ADDR_CHECK_EN - reject/truncate writes at
//               or above ADDR_LIMIT and raise the sticky addr_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_write_scheduler #(
    parameter int                DEPTH      = 16,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 12'hC00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         writable,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [7:0]                   req_data,
    input  logic                         fill_start,
    input  logic [ADDR_W-1:0]            fill_addr,
    input  logic [ADDR_W-1:0]            fill_len,
    input  logic [7:0]                   fill_data,
    output logic                         fill_busy,
    output logic                         vram_we,
    output logic [ADDR_W-1:0]            vram_addr,
    output logic [7:0]                   vram_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
    output logic                         addr_err,
`endif
    output logic                         idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t state, state_next;

    // FIFO storage and bookkeeping
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [7:0]        fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level, level_next;

    // Fill engine
    logic [ADDR_W-1:0] fill_ptr, fill_cnt, fill_ptr_inc;
    logic [7:0]        fill_byte;
    logic              busy;

    // Fill request captured while the FIFO is still draining
    logic              pending;
    logic [ADDR_W-1:0] pend_addr, pend_len;
    logic [7:0]        pend_data;

    // Last driven write-port values, held while not writing
    logic [ADDR_W-1:0] last_addr, src_addr;
    logic [7:0]        last_data, src_data;

    logic req_in_range, fill_in_range;
    logic push_hs, push, pop, adv, fill_req, fill_end, limit_hit;
    logic load_inputs, load_pend, latch_pend, fill_done;

    assign fill_ptr_inc = fill_ptr + ADDR_W'(1);

`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
    assign req_in_range  = (req_addr < ADDR_LIMIT);
    assign fill_in_range = (fill_ptr < ADDR_LIMIT);
    // A fill stops early either when it starts out of range or when its next
    // address would reach the limit with bytes still left to write.
    assign limit_hit = (state == ST_FILL) &&
                       (!fill_in_range ||
                        (adv && (fill_cnt != ADDR_W'(1)) && (fill_ptr_inc == ADDR_LIMIT)));
    assign fill_end  = (adv && (fill_cnt == ADDR_W'(1))) || limit_hit;
`else
    logic unused_limit;
    assign unused_limit  = ^ADDR_LIMIT;
    assign req_in_range  = 1'b1;
    assign fill_in_range = 1'b1;
    assign limit_hit     = 1'b0;
    assign fill_end      = adv && (fill_cnt == ADDR_W'(1));
`endif

    assign req_ready = (level != LVL_W'(DEPTH));
    assign push_hs   = req_valid && req_ready;
    assign push      = push_hs && req_in_range;

    assign vram_we = writable &&
                     (((state == ST_DRAIN) && (level != '0)) ||
                      ((state == ST_FILL) && fill_in_range));
    assign pop     = vram_we && (state == ST_DRAIN);
    assign adv     = vram_we && (state == ST_FILL);

    assign level_next = level + LVL_W'(push) - LVL_W'(pop);

    // A new fill is only taken when no fill is running or waiting.
    assign fill_req = fill_start && (fill_len != '0) && !busy && !pending;

    assign src_addr  = (state == ST_FILL) ? fill_ptr  : fifo_addr[rd_ptr];
    assign src_data  = (state == ST_FILL) ? fill_byte : fifo_data[rd_ptr];
    assign vram_addr = vram_we ? src_addr : last_addr;
    assign vram_data = vram_we ? src_data : last_data;

    assign fifo_level = level;
    assign fill_busy  = busy;
    assign idle       = (state == ST_IDLE) && (level == '0) && !pending;

    // Next-state logic
    always_comb begin
        state_next  = state;
        load_inputs = 1'b0;
        load_pend   = 1'b0;
        latch_pend  = 1'b0;
        fill_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A fill wins over freshly queued writes.
                if (fill_req) begin
                    state_next  = ST_FILL;
                    load_inputs = 1'b1;
                end else if (level != '0) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (level_next == '0) begin
                    if (pending) begin
                        state_next = ST_FILL;
                        load_pend  = 1'b1;
                    end else if (fill_req) begin
                        state_next  = ST_FILL;
                        load_inputs = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (fill_req) begin
                    latch_pend = 1'b1;
                end
            end
            ST_FILL: begin
                if (fill_end) begin
                    fill_done  = 1'b1;
                    state_next = (level_next != '0) ? ST_DRAIN : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req_addr;
            fifo_data[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            fill_ptr  <= '0;
            fill_cnt  <= '0;
            fill_byte <= '0;
            busy      <= 1'b0;
            pending   <= 1'b0;
            pend_addr <= '0;
            pend_len  <= '0;
            pend_data <= '0;
            last_addr <= '0;
            last_data <= '0;
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
            addr_err  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            level <= level_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            if (load_inputs) begin
                fill_ptr  <= fill_addr;
                fill_cnt  <= fill_len;
                fill_byte <= fill_data;
                busy      <= 1'b1;
            end else if (load_pend) begin
                fill_ptr  <= pend_addr;
                fill_cnt  <= pend_len;
                fill_byte <= pend_data;
                pending   <= 1'b0;
            end else if (adv) begin
                fill_ptr <= fill_ptr_inc;
                fill_cnt <= fill_cnt - ADDR_W'(1);
            end

            // busy already covers the pending interval.
            if (latch_pend) begin
                pending   <= 1'b1;
                busy      <= 1'b1;
                pend_addr <= fill_addr;
                pend_len  <= fill_len;
                pend_data <= fill_data;
            end

            if (fill_done) busy <= 1'b0;

            if (vram_we) begin
                last_addr <= src_addr;
                last_data <= src_data;
            end
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
            if ((push_hs && !req_in_range) || limit_hit) addr_err <= 1'b1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_write_scheduler
// Description : Scoreboard bench for vram_write_scheduler. Every accepted CPU
//               write or fill appends its expected VRAM writes to a queue in
//               program order; a monitor pops and compares on every vram_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_write_scheduler;

    localparam logic [11:0] LIMIT = 12'hC00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        writable = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        fill_start = 1'b0;
    logic [11:0] fill_addr = '0;
    logic [11:0] fill_len = '0;
    logic [7:0]  fill_data = '0;
    logic        fill_busy;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [4:0]  fifo_level;
    logic        idle;
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
    logic        addr_err;
`endif

    vram_write_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .writable   (writable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_len   (fill_len),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .fifo_level (fifo_level),
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
        .addr_err   (addr_err),
`endif
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
        bit          f;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   fill_outstanding = 0;
    int   wr_seen = 0;
    bit   exp_err = 1'b0;

    function automatic bit in_range(input logic [11:0] a);
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
        return a < LIMIT;
`else
        return (a == a);
`endif
    endfunction

    // Reference model: a CPU write is either queued or flagged as an error.
    function automatic void model_push(input logic [11:0] a, input logic [7:0] d);
        exp_t e;
        if (in_range(a)) begin
            e.a = a; e.d = d; e.f = 1'b0;
            q.push_back(e);
        end else begin
            exp_err = 1'b1;
        end
    endfunction

    // Reference model: a fill expands into len consecutive (wrapping) bytes,
    // cut short at the first out-of-range address.
    function automatic void model_fill(input logic [11:0] a0, input logic [11:0] len,
                                       input logic [7:0] d);
        exp_t e;
        logic [11:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = a0 + 12'(i);
            if (!in_range(a)) begin
                exp_err = 1'b1;
                break;
            end
            e.a = a; e.d = d; e.f = 1'b1;
            q.push_back(e);
            fill_outstanding++;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every VRAM write must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst && vram_we) begin
            wr_seen++;
            vectors++;
            if (!writable) begin
                miscompares++;
                $display("FAIL write_blocked: vram_we=1 while writable=0 addr %0h", vram_addr);
            end
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         vram_addr, vram_data);
            end else begin
                e = q.pop_front();
                if (e.f) fill_outstanding--;
                if (vram_addr !== e.a || vram_data !== e.d) begin
                    miscompares++;
                    $display("FAIL write: got %0h/%0h expected %0h/%0h",
                             vram_addr, vram_data, e.a, e.d);
                end
            end
        end
    end

    // One clock: record what the DUT accepts this cycle, then advance.
    task automatic tick();
        @(negedge clk);
        if (fill_start && fill_len != 0 && fill_outstanding == 0)
            model_fill(fill_addr, fill_len, fill_data);
        if (req_valid && req_ready) model_push(req_addr, req_data);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        writable = 1'b1; req_valid = 1'b0; fill_start = 1'b0;
        while (!(idle && !fill_busy && q.size() == 0) && n < bound) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= bound) begin
            miscompares++;
            $display("FAIL wait_idle: got idle=%0d queued=%0d expected idle=1 queued=0",
                     idle, q.size());
        end
    endtask

    task automatic pulse_fill(input logic [11:0] a, input logic [11:0] len, input logic [7:0] d);
        fill_start = 1'b1; fill_addr = a; fill_len = len; fill_data = d;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic push1(input logic [11:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_addr = a; req_data = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, acc, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_idle", idle, 1);
        check("rst_vram_we", vram_we, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_vram_addr", vram_addr, 0);
        check("rst_vram_data", vram_data, 0);
        rst = 1'b1;
        tick();

        // Three writes queued while blocked, then drained back to back
        writable = 1'b0;
        push1(12'h010, 8'hAA);
        push1(12'h011, 8'hBB);
        push1(12'h3C0, 8'h1B);
        tick();
        check("blk_fifo_level", fifo_level, 3);
        check("blk_req_ready", req_ready, 1);
        check("blk_vram_we", vram_we, 0);
        base = wr_seen;
        writable = 1'b1;
        repeat (3) tick();
        check("burst_writes", wr_seen - base, 3);
        tick();
        check("burst_idle", idle, 1);

        // FIFO full: 20 cycles of requests, only DEPTH accepted
        writable = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1;
            req_addr = 12'($urandom_range(0, 12'hBFF));
            req_data = 8'($urandom);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        check("full_accepted", acc, 16);
        check("full_level", fifo_level, 16);
        check("full_ready", req_ready, 0);
        wait_idle(100);

        // Nametable clear with writable toggling every 50 cycles
        base = wr_seen;
        writable = 1'b1;
        pulse_fill(12'h800, 12'd960, 8'h00);
        check("fill_busy_on", fill_busy, 1);
        n = 0;
        while (!(idle && q.size() == 0) && n < 4000) begin
            if (n % 50 == 0) writable = ~writable;
            tick();
            n++;
        end
        check("clear_timeout", (n < 4000), 1);
        check("clear_writes", wr_seen - base, 960);
        check("clear_busy_off", fill_busy, 0);
        wait_idle(10);

        // Fill requested mid-drain waits for queued writes; later push follows fill
        writable = 1'b0;
        push1(12'h020, 8'h11);
        push1(12'h021, 8'h22);
        pulse_fill(12'h100, 12'd4, 8'h5A);
        check("pend_busy", fill_busy, 1);
        check("pend_idle", idle, 0);
        writable = 1'b1;
        repeat (3) tick();
        fill_start = 1'b1; fill_addr = 12'h700; fill_len = 12'd8; fill_data = 8'hEE;
        push1(12'h222, 8'h77);
        fill_start = 1'b0;
        wait_idle(40);

        // Zero-length fill is ignored
        pulse_fill(12'h300, 12'd0, 8'h99);
        check("zero_len_busy", fill_busy, 0);
        check("zero_len_idle", idle, 1);

        // Wrap-around fill and a high address write
        pulse_fill(12'hFFE, 12'd4, 8'h3C);
        wait_idle(20);
        push1(12'hC05, 8'h42);
        wait_idle(20);
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
        check("addr_err", addr_err, exp_err);
`endif

        // Randomized mix of fills and CPU writes
        for (int it = 0; it < 30; it++) begin
            wait_idle(200);
            if ($urandom_range(0, 1) == 1)
                pulse_fill(12'($urandom), 12'($urandom_range(1, 40)), 8'($urandom));
            for (int c = 0; c < 30; c++) begin
                writable  = ($urandom_range(0, 9) < 7);
                req_valid = $urandom_range(0, 1) == 1;
                req_addr  = 12'($urandom);
                req_data  = 8'($urandom);
                tick();
            end
            req_valid = 1'b0;
        end
        wait_idle(300);
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
        check("rand_addr_err", addr_err, exp_err);
`endif

        // Reset asserted partway through a fill
        base = wr_seen;
        writable = 1'b1;
        pulse_fill(12'h000, 12'd100, 8'hC3);
        n = 0;
        while ((wr_seen - base) < 10 && n < 200) begin
            tick();
            n++;
        end
        rst = 1'b0;
        #1;
        check("mid_rst_we", vram_we, 0);
        check("mid_rst_busy", fill_busy, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_idle", idle, 1);
        q.delete();
        fill_outstanding = 0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        base = wr_seen;
        repeat (30) tick();
        check("post_rst_writes", wr_seen - base, 0);
        check("post_rst_idle", idle, 1);
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
        check("post_rst_addr_err", addr_err, 0);
`endif

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
